// File: rtl/switch_fifo_port.sv
// Buffered switch input: each debounced enter_key press captures switches into a FIFO
// that the CPU drains through the a0/ack read port. Define SWFIFO_DEBOUNCE_EN to enable the debouncer.
module switch_fifo_port #(
    parameter int unsigned DEPTH           = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] switches,
    input  logic        enter_key,
    input  logic        a0,
    input  logic        ack,
    output logic [15:0] data_out,
    output logic        ready
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          ready_d;
    logic [1:0]    sync_q;
    logic [1:0]    fill_q;
    logic          armed_q;
    logic          db_lvl, prev_q;
    logic          push_ev, push_ok, pop, full, empty;
    logic [4:0]    count5;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            fill_q  <= 2'd0;
            armed_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], enter_key};
            if (!fill_q[1]) fill_q <= fill_q + 2'd1;
            // A key held through reset must be seen released before it can push.
            if (fill_q[1] && !sync_q[1]) armed_q <= 1'b1;
            prev_q <= db_lvl;
        end
    end

`ifdef SWFIFO_DEBOUNCE_EN
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DBW-1:0] db_cnt_q;
    logic           db_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_cnt_q <= '0;
            db_q     <= 1'b0;
        end else if (sync_q[1] != db_q) begin
            if (db_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
                db_q     <= ~db_q;
                db_cnt_q <= '0;
            end else begin
                db_cnt_q <= db_cnt_q + 1'b1;
            end
        end else begin
            db_cnt_q <= '0;
        end
    end
    assign db_lvl = db_q;
`else
    assign db_lvl = sync_q[1];
`endif

    always_comb begin
        empty      = (count_q == '0);
        full       = (count_q == CW'(DEPTH));
        push_ev    = db_lvl && !prev_q && armed_q;
        pop        = ack && !a0 && !empty;
        push_ok    = push_ev && (!full || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        if (push_ok && !pop) count_d = count_q + 1'b1;
        else if (pop && !push_ok) count_d = count_q - 1'b1;
        // A set in the same cycle as a clear wins.
        overflow_d = (push_ev && full && !pop) || (overflow_q && !(ack && a0));
        ready_d    = (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            ready      <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            ready      <= ready_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= switches;
    end

    always_comb begin
        count5 = 5'(count_q);
        if (a0) data_out = {3'b000, count5, 5'b00000, overflow_q, full, !empty};
        else if (!empty) data_out = mem[rd_ptr_q];
        else data_out = 16'h0000;
    end
endmodule

// File: doc/switch_fifo_port.md
# switch_fifo_port

Memory-mapped, buffered input device for the bird CPU data-input multiplexer, one level above the plain switch bank. Each debounced press of `enter_key` captures the 16-bit switch value into a FIFO. The CPU polls a status word and pops captured values through the same `a0`/`ack` read protocol the top level already uses for SWITCHBANK_DATA (0x900, a0=0) and SWITCHBANK_STATUS (0x901, a0=1). The block thus buffers operator input so that presses arriving during long CPU routines are not lost.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, 2..16.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a key level change (1 ms at 50 MHz).

- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `switches`  in  16  raw switch value, sampled at push time.
- `enter_key`  in  1  raw asynchronous push button, active-high.
- `a0`  in  1  register select: 0 = data, 1 = status.
- `ack`  in  1  read strobe; high in every cycle the CPU address decodes to 0x900/0x901.
- `data_out`  out  16  read data, combinational from `a0` and state.
- `ready`  out  1  registered; high while FIFO is non-empty.

## Operation
- Input path: `enter_key` passes through a 2-flop synchronizer, then the debouncer (see Configuration), then a rising-edge detector. One push per debounced 0→1 transition; holding the key pushes nothing further.
- Push: writes the `switches` value registered in the same cycle as the edge into `mem[wr_ptr]`, then increments `wr_ptr` modulo DEPTH and increments `count`.
- Pop: occurs on `ack && !a0 && count != 0`. Increments `rd_ptr` modulo DEPTH and decrements `count`. A pop on empty is a no-op.
- Status word (`a0=1`):
  - bit0 = ready (count != 0)
  - bit1 = full (count == DEPTH)
  - bit2 = overflow (sticky)
  - bits[12:8] = count
  - all other bits 0.
- Data word (`a0=0`): `mem[rd_ptr]` when non-empty, 16'h0000 when empty.
- Overflow: a push while full with no simultaneous pop is dropped, and `overflow` is set. The FIFO contents are unchanged, so the oldest data is kept.
- Overflow clear: `ack && a0` clears `overflow` at the end of that cycle, so the read itself still returns 1. A set and a clear in the same cycle leave the flag at 1.
- Simultaneous push and pop:
  - Non-empty: both happen and `count` is unchanged, including when full, with no overflow.
  - Empty: the pop is ignored and the push happens.
- `ack` held high for N cycles with `a0=0` pops up to N entries. The top level asserts `ack` only during the single-cycle CPU read.

## Timing
- Reset, asynchronous: pointers, count, overflow, synchronizer flops and debounce counter are all 0; the debounced level is 0; `ready` = 0; `data_out` = 16'h0000 for either `a0`. FIFO storage is not reset.
- Deassertion of `rst_n` mid-press: the key must be seen as released, then pressed, before the next push.
- Push latency: from the first `enter_key` high at the synchronizer input, the entry is visible in `count` after 2 + DEBOUNCE_CYCLES + 1 cycles.
- `data_out` follows `a0` and the state combinationally in the same cycle. A pop takes effect at the clock edge ending the `ack` cycle. The next head is visible in the following cycle.
- `ready` updates on the same edge as `count`.

## Configuration
- `SWFIFO_DEBOUNCE_EN` defined: a counter runs while the synchronized level differs from the debounced level. It resets to 0 on any match. When it reaches DEBOUNCE_CYCLES, the debounced level toggles.
- Not defined: the debounced level equals the synchronizer output. `DEBOUNCE_CYCLES` is ignored, push latency is 3 cycles, and every bounce edge pushes.

## Test plan
- Reset: hold `rst_n`=0 with `enter_key`=1 and `switches`=16'hFFFF → status 16'h0000, `ready`=0, data 16'h0000; after release, no push until the key is released and pressed again.
- Debounce (DEBOUNCE_CYCLES=4, macro defined): pulse the key high for 3 cycles, 10 times, then hold high for 6 cycles with `switches`=16'h3136 → exactly one push; status 16'h0101; data read returns 16'h3136, then status 16'h0000.
- Ordering: push 16'h0001, 16'h0002, 16'h0003 → three data reads return them in order; a fourth read returns 16'h0000 and count stays 0.
- Full/overflow (DEPTH=4): 5 pushes of 16'hA000..16'hA004 → status 16'h0407; data reads return A000..A003; the first status read returns bit2=1, the second returns bit2=0.
- Simultaneous push and pop at full (DEPTH=4): pop in the edge cycle of the 5th push → status 16'h0403, no overflow; the last entry read is 16'hA004.
- Macro undefined: a single 1-cycle key glitch → one push; status 16'h0101 within 3 cycles.
